// File: rtl/ets_sweep_sequencer_if.sv
// Signal bundle between the ETS sweep sequencer and its surroundings
// (MMCM phase-shift port, capture core, frame buffer controller).
interface ets_sweep_sequencer_if;
  logic        en;
  logic        incdec;
  logic        ps_done;
  logic        cap_done;
  logic        frame_ack;
  logic        ps_en;
  logic        ps_incdec;
  logic        cap_start;
  logic [8:0]  step_idx;
  logic        frame_done;
  logic        busy;
  logic        timeout_err;
  logic [31:0] phase_counter;

  // master is the sequencer itself; slave is whatever drives its inputs
  modport master (
    input  en, incdec, ps_done, cap_done, frame_ack,
    output ps_en, ps_incdec, cap_start, step_idx, frame_done, busy,
           timeout_err, phase_counter
  );

  modport slave (
    output en, incdec, ps_done, cap_done, frame_ack,
    input  ps_en, ps_incdec, cap_start, step_idx, frame_done, busy,
           timeout_err, phase_counter
  );
endinterface

// File: rtl/ets_sweep_sequencer.sv
// Phase-sweep sequencer: steps the MMCM phase shifter once per sample, waits
// for the shift to finish and settle, then requests one comparator capture.
module ets_sweep_sequencer #(
  parameter int STEPS      = 448,
  parameter int SETTLE     = 16,
  parameter int PS_TIMEOUT = 1023
) (
  input  logic                  shifting_clk,
  input  logic                  reset_n,
  ets_sweep_sequencer_if.master sweep
);

  localparam int TO_W = $clog2(PS_TIMEOUT + 1);
  localparam int ST_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [8:0]      LAST_IDX = 9'(STEPS - 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(PS_TIMEOUT);
  localparam logic [ST_W-1:0] ST_LOAD  = ST_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT_DONE,
    S_SETTLE,
    S_CAPTURE,
    S_ADVANCE,
    S_FRAME,
    S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [8:0]      step_q, step_d;
  logic            dir_q, dir_d;
  logic [TO_W-1:0] tcnt_q, tcnt_d, tcnt_inc;
  logic [ST_W-1:0] scnt_q, scnt_d;
  logic            ps_en_q;
  logic            cap_start_q, cap_start_d;
  logic            frame_done_q, frame_done_d;
  logic            err_q, err_d;
  logic [31:0]     phase_cnt_q;

  assign tcnt_inc = tcnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    dir_d        = dir_q;
    tcnt_d       = tcnt_q;
    scnt_d       = scnt_q;
    cap_start_d  = 1'b0;
    frame_done_d = frame_done_q;
    err_d        = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (sweep.en) begin
          dir_d   = sweep.incdec;
          step_d  = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        tcnt_d  = '0;
        state_d = S_WAIT_DONE;
      end

      // ps_done wins over a timeout landing in the same cycle
      S_WAIT_DONE: begin
        if (sweep.ps_done) begin
          scnt_d  = ST_LOAD;
          state_d = S_SETTLE;
        end else begin
          tcnt_d = tcnt_inc;
          if (tcnt_inc == TO_LIMIT) begin
            err_d   = 1'b1;
            state_d = S_ERROR;
          end
        end
      end

      S_SETTLE: begin
        if (scnt_q == '0) begin
          cap_start_d = 1'b1;
          state_d     = S_CAPTURE;
        end else begin
          scnt_d = scnt_q - 1'b1;
        end
      end

      S_CAPTURE: begin
        if (sweep.cap_done) begin
          state_d = S_ADVANCE;
        end
      end

      S_ADVANCE: begin
        if (step_q == LAST_IDX) begin
          frame_done_d = 1'b1;
          state_d      = S_FRAME;
        end else begin
          step_d  = step_q + 1'b1;
          state_d = sweep.en ? S_SHIFT : S_IDLE;
        end
      end

      // the next frame takes its direction at the moment the buffer accepts this one
      S_FRAME: begin
        if (sweep.frame_ack) begin
          frame_done_d = 1'b0;
          step_d       = '0;
          dir_d        = sweep.incdec;
          state_d      = sweep.en ? S_SHIFT : S_IDLE;
        end
      end

      S_ERROR: begin
        if (!sweep.en) begin
          err_d   = 1'b0;
          step_d  = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge shifting_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      dir_q        <= 1'b0;
      tcnt_q       <= '0;
      scnt_q       <= '0;
      ps_en_q      <= 1'b0;
      cap_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      dir_q        <= dir_d;
      tcnt_q       <= tcnt_d;
      scnt_q       <= scnt_d;
      ps_en_q      <= (state_q == S_SHIFT);
      cap_start_q  <= cap_start_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  // counts every completed shift, including ones the FSM is not waiting for
  always_ff @(posedge shifting_clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_cnt_q <= '0;
    end else if (sweep.ps_done) begin
      phase_cnt_q <= phase_cnt_q + 32'd1;
    end
  end

  assign sweep.ps_en         = ps_en_q;
  assign sweep.ps_incdec     = dir_q;
  assign sweep.cap_start     = cap_start_q;
  assign sweep.step_idx      = step_q;
  assign sweep.frame_done    = frame_done_q;
  assign sweep.busy          = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign sweep.timeout_err   = err_q;
  assign sweep.phase_counter = phase_cnt_q;

endmodule

// File: tb/tb_ets_sweep_sequencer.sv
// Randomized scoreboard bench for ets_sweep_sequencer: the stimulus process
// predicts output events by cycle, a negedge monitor pops and compares them.
module tb_ets_sweep_sequencer;
  localparam int STEPS      = 4;
  localparam int SETTLE     = 2;
  localparam int PS_TIMEOUT = 8;

  localparam int EV_PSEN   = 0;
  localparam int EV_CAP    = 1;
  localparam int EV_FRISE  = 2;
  localparam int EV_FFALL  = 3;
  localparam int EV_ERR    = 4;
  localparam int EV_ERRCLR = 5;

  typedef struct {
    int kind;
    int cyc;
    int idx;
    bit dir;
    bit busy;
  } ev_t;

  logic shifting_clk = 1'b0;
  logic reset_n;

  ets_sweep_sequencer_if sif();

  ets_sweep_sequencer #(
    .STEPS(STEPS),
    .SETTLE(SETTLE),
    .PS_TIMEOUT(PS_TIMEOUT)
  ) dut (
    .shifting_clk(shifting_clk),
    .reset_n(reset_n),
    .sweep(sif)
  );

  always #5 shifting_clk = ~shifting_clk;

  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  int     nframes = 0;
  longint pd_model = 0;
  bit     mon_en = 1'b0;
  bit     fd_prev = 1'b0;
  bit     te_prev = 1'b0;
  ev_t    exp_q[$];

  always @(posedge shifting_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int idx, input bit dir, input bit busy);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.idx  = idx;
    e.dir  = dir;
    e.busy = busy;
    exp_q.push_back(e);
  endtask

  task automatic take_event(input int kind);
    ev_t e;
    bit  bad;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d cycle=%0d idx=%0d, expected no event",
               kind, cyc, sif.step_idx);
    end else begin
      e = exp_q.pop_front();
      bad = (e.kind != kind) || (e.cyc != cyc) || (e.idx != int'(sif.step_idx)) ||
            (e.busy != sif.busy) || (kind == EV_PSEN && e.dir != sif.ps_incdec);
      if (bad) begin
        errors++;
        $display("FAIL event: got kind=%0d cyc=%0d idx=%0d dir=%0d busy=%0d, expected kind=%0d cyc=%0d idx=%0d dir=%0d busy=%0d",
                 kind, cyc, sif.step_idx, sif.ps_incdec, sif.busy,
                 e.kind, e.cyc, e.idx, e.dir, e.busy);
      end
    end
    chk("phase_counter", longint'(sif.phase_counter), pd_model - (sif.ps_done ? 1 : 0));
  endtask

  // Monitor: detects output events and matches them against the prediction queue
  always @(negedge shifting_clk) begin
    if (mon_en) begin
      if (sif.ps_en) take_event(EV_PSEN);
      if (sif.cap_start) take_event(EV_CAP);
      if (sif.frame_done && !fd_prev) take_event(EV_FRISE);
      if (!sif.frame_done && fd_prev) take_event(EV_FFALL);
      if (sif.timeout_err && !te_prev) take_event(EV_ERR);
      if (!sif.timeout_err && te_prev) take_event(EV_ERRCLR);
    end
    fd_prev = sif.frame_done;
    te_prev = sif.timeout_err;
  end

  task automatic tick();
    @(posedge shifting_clk);
    #1;
    sif.ps_done   = 1'b0;
    sif.cap_done  = 1'b0;
    sif.frame_ack = 1'b0;
    sif.incdec    = 1'($urandom_range(0, 1));
  endtask

  task automatic goto(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ps_en"}, longint'(sif.ps_en), 0);
    chk({tag, "_ps_incdec"}, longint'(sif.ps_incdec), 0);
    chk({tag, "_cap_start"}, longint'(sif.cap_start), 0);
    chk({tag, "_step_idx"}, longint'(sif.step_idx), 0);
    chk({tag, "_frame_done"}, longint'(sif.frame_done), 0);
    chk({tag, "_busy"}, longint'(sif.busy), 0);
    chk({tag, "_timeout_err"}, longint'(sif.timeout_err), 0);
    chk({tag, "_phase_counter"}, longint'(sif.phase_counter), 0);
  endtask

  // Runs nsteps phase steps from IDLE with random response delays, random
  // stops and stray events; always ends back in IDLE.
  task automatic run_steps(input int nsteps, input bit force_edge);
    int p, t, c, a, d, idx;
    bit dir, stop;
    tick();
    sif.en = 1'b1;
    dir = sif.incdec;
    idx = 0;
    p = cyc + 2;
    for (int s = 0; s < nsteps; s++) begin
      push(EV_PSEN, p, idx, dir, 1'b1);
      d = (force_edge && s == 1) ? PS_TIMEOUT - 1 : int'($urandom_range(0, PS_TIMEOUT - 1));
      t = p + d;
      goto(p);
      while (cyc < t) begin
        sif.cap_done  = ($urandom_range(0, 3) == 0);
        sif.frame_ack = ($urandom_range(0, 3) == 0);
        tick();
      end
      sif.ps_done = 1'b1;
      pd_model++;
      for (int i = 0; i < SETTLE; i++) begin
        tick();
        if ($urandom_range(0, 3) == 0) begin
          sif.ps_done = 1'b1;
          pd_model++;
        end
      end
      push(EV_CAP, t + SETTLE + 1, idx, dir, 1'b1);
      c = t + SETTLE + 1 + int'($urandom_range(0, 3));
      goto(c);
      sif.cap_done = 1'b1;
      stop = (s == nsteps - 1) || ($urandom_range(0, 7) == 0);
      sif.en = !stop;
      if (idx == STEPS - 1) begin
        push(EV_FRISE, c + 2, idx, dir, 1'b1);
        nframes++;
        a = c + 2 + ((nframes == 1) ? 19 : (nframes == 2) ? 0 : int'($urandom_range(0, 12)));
        goto(a);
        sif.frame_ack = 1'b1;
        sif.en = !stop;
        push(EV_FFALL, a + 1, 0, dir, !stop);
        idx = 0;
        if (!stop) begin
          dir = sif.incdec;
          p = a + 2;
        end else begin
          goto(a + 1);
          chk("idle_after_frame_busy", longint'(sif.busy), 0);
          chk("idle_after_frame_idx", longint'(sif.step_idx), 0);
        end
      end else begin
        idx++;
        if (!stop) begin
          p = c + 3;
        end else begin
          goto(c + 2);
          chk("stop_busy", longint'(sif.busy), 0);
          chk("stop_step_idx", longint'(sif.step_idx), idx);
        end
      end
      if (stop && s != nsteps - 1) begin
        sif.en = 1'b1;
        dir = sif.incdec;
        idx = 0;
        p = cyc + 2;
      end
    end
  endtask

  initial begin
    int p, t;
    bit dir;
    reset_n       = 1'b0;
    sif.en        = 1'b0;
    sif.incdec    = 1'b0;
    sif.ps_done   = 1'b0;
    sif.cap_done  = 1'b0;
    sif.frame_ack = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();
    mon_en = 1'b1;

    run_steps(60, 1'b1);

    // Timeout: ps_done never comes
    tick();
    sif.en = 1'b1;
    dir = sif.incdec;
    p = cyc + 2;
    push(EV_PSEN, p, 0, dir, 1'b1);
    push(EV_ERR, p + PS_TIMEOUT, 0, dir, 1'b0);
    goto(p + PS_TIMEOUT + 6);
    chk("err_flag", longint'(sif.timeout_err), 1);
    chk("err_busy", longint'(sif.busy), 0);
    sif.en = 1'b0;
    push(EV_ERRCLR, cyc + 1, 0, dir, 1'b0);
    tick();
    tick();
    chk("err_cleared", longint'(sif.timeout_err), 0);
    chk("err_idle_busy", longint'(sif.busy), 0);
    chk("err_idle_idx", longint'(sif.step_idx), 0);

    run_steps(12, 1'b0);

    // Asynchronous reset while settling
    tick();
    sif.en = 1'b1;
    dir = sif.incdec;
    p = cyc + 2;
    push(EV_PSEN, p, 0, dir, 1'b1);
    t = p + int'($urandom_range(0, PS_TIMEOUT - 1));
    goto(t);
    sif.ps_done = 1'b1;
    pd_model++;
    tick();
    chk("settle_busy", longint'(sif.busy), 1);
    chk("pre_reset_queue", longint'(exp_q.size()), 0);
    #2;
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    sif.en = 1'b0;
    pd_model = 0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    mon_en = 1'b1;
    sif.ps_done = 1'b1;
    pd_model++;
    tick();
    tick();
    chk("stray_phase_counter", longint'(sif.phase_counter), 1);
    chk("stray_busy", longint'(sif.busy), 0);
    chk("stray_step_idx", longint'(sif.step_idx), 0);

    repeat (10) tick();
    chk("scoreboard_drained", longint'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
